// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled line, 3-sample majority vote per bit, one-cycle
// data_valid / stop_err strobes, resynchronises after a framing error once the line idles.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       stop_err,
  output logic       busy
);

  localparam int unsigned EW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [EW-1:0] EdgeSamp0 = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] EdgeSamp1 = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] EdgeVote  = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] EdgeLast  = EW'(OVERSAMPLE - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitIdle = 3'd4;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [2:0]    bit_q, bit_d;
  logic          samp0_q, samp0_d;
  logic          samp1_q, samp1_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    p_data_q, p_data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          vote;
  logic          is_vote;
  logic          is_last;

  assign rx_s    = sync_q[1];
  assign vote    = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
  assign is_vote = (edge_q == EdgeVote);
  assign is_last = (edge_q == EdgeLast);

  always_comb begin
    state_d  = state_q;
    edge_d   = is_last ? '0 : edge_q + 1'b1;
    bit_d    = bit_q;
    samp0_d  = (edge_q == EdgeSamp0) ? rx_s : samp0_q;
    samp1_d  = (edge_q == EdgeSamp1) ? rx_s : samp1_q;
    shift_d  = shift_q;
    p_data_d = p_data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        edge_d = '0;
        bit_d  = '0;
        // The detection cycle itself counts as edge 0 of the start bit.
        if (!rx_s) begin
          state_d = StStart;
          edge_d  = EW'(1);
        end
      end
      StStart: begin
        if (is_vote && vote) begin
          state_d = StIdle;
          edge_d  = '0;
        end else if (is_last) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (is_vote) shift_d = {vote, shift_q[7:1]};
        if (is_last) begin
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        // Leave at the stop-bit vote so a back-to-back start edge is not missed.
        if (is_vote) begin
          edge_d = '0;
          if (vote) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
            state_d  = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        edge_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        edge_d  = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= StIdle;
      edge_q   <= '0;
      bit_q    <= '0;
      samp0_q  <= 1'b1;
      samp1_q  <= 1'b1;
      shift_q  <= '0;
      p_data_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_in};
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      samp0_q  <= samp0_d;
      samp1_q  <= samp1_d;
      shift_q  <= shift_d;
      p_data_q <= p_data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = valid_q;
  assign stop_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a negedge monitor checks them.
module tb_uart_rx;

  localparam int OS = 8;
  // Cycle count from driving the start bit to seeing the strobe: 2 sync cycles + 9*OS+OS/2+2.
  localparam int StrobeLat = 9 * OS + OS / 2 + 4;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] p_data;
  logic       data_valid;
  logic       stop_err;
  logic       busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .p_data    (p_data),
    .data_valid(data_valid),
    .stop_err  (stop_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       sb_q[$];
  bit         exp_busy[int];
  logic [7:0] exp_pdata[int];
  logic [7:0] last_good;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         done = 1'b0;
  exp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: checks strobes against the scoreboard and cycle-tagged expectations.
  always @(negedge clk) begin
    if (exp_busy.exists(cyc)) check("busy", 32'(busy), 32'(exp_busy[cyc]));
    if (exp_pdata.exists(cyc)) check("p_data_level", 32'(p_data), 32'(exp_pdata[cyc]));
    if (data_valid === 1'b1 || stop_err === 1'b1) begin
      check("strobe_exclusive", 32'(data_valid & stop_err), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'({data_valid, stop_err}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe_kind", 32'({data_valid, stop_err}), mon_e.is_err ? 32'd1 : 32'd2);
        check("strobe_cycle", 32'(cyc), 32'(mon_e.at));
        check("p_data", 32'(p_data), 32'(mon_e.data));
      end
    end
    if (done) begin
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic drive(input logic v, input int ncyc);
    rx_in = v;
    repeat (ncyc) @(negedge clk);
  endtask

  // Reference: a good frame yields its byte; a bad stop bit yields stop_err with p_data held.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit noise);
    exp_t e;
    e.is_err = !stop;
    e.data   = stop ? d : last_good;
    e.at     = cyc + StrobeLat;
    sb_q.push_back(e);
    if (stop) last_good = d;
    drive(1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        drive(d[i], OS / 2);
        drive(~d[i], 1);
        drive(d[i], OS / 2 - 1);
      end else begin
        drive(d[i], OS);
      end
    end
    drive(stop, OS);
  endtask

  initial begin : stim
    int         n;
    int         m;
    logic [7:0] d;
    bit         stop;
    bit         noise;

    rst       = 1'b1;
    rx_in     = 1'b1;
    last_good = 8'h00;
    exp_busy[2]  = 1'b0;
    exp_pdata[2] = 8'h00;
    exp_busy[3]  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5);

    // Single frame, busy window T0+1..T0+77.
    n = cyc;
    exp_busy[n + 2]  = 1'b0;
    exp_busy[n + 3]  = 1'b1;
    exp_busy[n + 79] = 1'b1;
    exp_busy[n + 80] = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 10);

    // Reset after four data bits of 0x81.
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(i == 0, OS);
    n = cyc;
    exp_busy[n]      = 1'b1;
    exp_busy[n + 1]  = 1'b0;
    exp_pdata[n + 1] = 8'h00;
    rst   = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    last_good = 8'h00;
    drive(1'b1, 4);
    send_frame(8'h81, 1'b1, 1'b0);
    drive(1'b1, 6);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive(1'b1, 10);

    // Start glitch: three low cycles.
    n = cyc;
    exp_busy[n + 3]          = 1'b1;
    exp_busy[n + 2 + OS / 2 + 1] = 1'b1;
    exp_busy[n + 2 + OS / 2 + 2] = 1'b0;
    drive(1'b0, 3);
    drive(1'b1, 20);
    send_frame(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 10);

    // Framing error, line held low 30 more cycles.
    n = cyc;
    m = n + 10 * OS + 30;
    exp_busy[n + StrobeLat] = 1'b1;
    exp_busy[m + 2]  = 1'b1;
    exp_busy[m + 3]  = 1'b0;
    exp_pdata[m + 3] = 8'h3C;
    send_frame(8'h5A, 1'b0, 1'b0);
    drive(1'b0, 30);
    drive(1'b1, 10);
    send_frame(8'hC3, 1'b1, 1'b0);
    drive(1'b1, 5);

    // Mid-bit noise on every data bit.
    send_frame(8'h96, 1'b1, 1'b1);
    drive(1'b1, 5);

    // Randomised frames: data, stop validity, noise and gaps.
    repeat (24) begin
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      noise = 1'($urandom_range(0, 1));
      send_frame(d, stop, noise);
      if (!stop) drive(1'b0, $urandom_range(0, 20));
      drive(1'b1, stop ? $urandom_range(0, 3) : $urandom_range(1, 5));
    end

    drive(1'b1, 120);
    done = 1'b1;
  end

endmodule
